// File: rtl/ook_demod_pkg.sv
// Shared types and default timing constants for the OOK demodulator.
package ook_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        TRACK = 1'b1
    } state_t;

    localparam int unsigned DEF_CARRIER_DIV = 25;
    localparam int unsigned DEF_BIT_CYCLES  = 12500;
    localparam int unsigned DEF_GAP_CYCLES  = 50;
    localparam int unsigned DEF_IDLE_BITS   = 8;

endpackage

// File: rtl/ook_demod_carrier_detect.sv
// Carrier presence detector: input synchronizer, rising-edge pulse and a
// saturating gap counter that times out when carrier edges stop arriving.
module carrier_detect
    import ook_pkg::*;
#(
    parameter int unsigned CARRIER_DIV = DEF_CARRIER_DIV,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_mod_in,
    output logic o_carrier_det
);

    // Gap must span at least two carrier periods or the detector chatters.
    localparam int unsigned GAP_EFF = (GAP_CYCLES < 2 * CARRIER_DIV) ? 2 * CARRIER_DIV : GAP_CYCLES;
    localparam int unsigned GW      = $clog2(GAP_EFF + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_EFF);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_sync3;
    logic          r_edge;
    logic [GW-1:0] r_gap_cnt;
    logic          r_carrier_det;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_sync3       <= 1'b0;
            r_edge        <= 1'b0;
            r_gap_cnt     <= GAP_MAX;
            r_carrier_det <= 1'b0;
        end else begin
            r_sync1 <= i_mod_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_edge  <= r_sync2 & ~r_sync3;
            if (r_edge) begin
                r_gap_cnt <= '0;
            end else if (r_gap_cnt != GAP_MAX) begin
                r_gap_cnt <= r_gap_cnt + GW'(1);
            end
            r_carrier_det <= (r_gap_cnt < GAP_MAX);
        end
    end

    assign o_carrier_det = r_carrier_det;

endmodule

// File: rtl/ook_demod.sv
// OOK demodulator: locks bit timing to carrier on/off transitions and makes
// a majority decision on carrier presence per recovered bit period.
module ook_demod
    import ook_pkg::*;
#(
    parameter int unsigned CARRIER_DIV = DEF_CARRIER_DIV,
    parameter int unsigned BIT_CYCLES  = DEF_BIT_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned IDLE_BITS   = DEF_IDLE_BITS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic mod_in,
    output logic carrier_det,
    output logic data_out,
    output logic data_valid,
    output logic bit_clk,
    output logic locked
);

    localparam int unsigned BW = $clog2(BIT_CYCLES);
    localparam int unsigned ZW = $clog2(IDLE_BITS + 1);
    localparam logic [BW-1:0] HALF   = BW'(BIT_CYCLES / 2);
    localparam logic [BW:0]   HALF_W = (BW + 1)'(BIT_CYCLES / 2);
    localparam logic [BW-1:0] LAST   = BW'(BIT_CYCLES - 1);
    localparam logic [ZW-1:0] ZMAX   = ZW'(IDLE_BITS);

    state_t        r_state;
    state_t        w_state_nx;
    logic [BW-1:0] r_bit_cnt;
    logic [BW-1:0] w_bit_cnt_nx;
    logic [BW-1:0] r_ones_cnt;
    logic [BW-1:0] w_ones_cnt_nx;
    logic [ZW-1:0] r_zero_run;
    logic [ZW-1:0] w_zero_run_nx;
    logic          r_cd_d;
    logic          r_data_out;
    logic          w_data_out_nx;
    logic          r_data_valid;
    logic          w_data_valid_nx;
    logic          r_bit_clk;
    logic          w_bit_clk_nx;
    logic          w_carrier_det;
    logic          w_rise;
    logic          w_trans;
    logic          w_decide;
    logic          w_dec_bit;
    logic [BW:0]   w_ones_sum;
    logic [BW:0]   w_twice_ones;
    logic [BW:0]   w_cnt_plus1;

    carrier_detect #(
        .CARRIER_DIV(CARRIER_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_carrier_detect (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_mod_in     (mod_in),
        .o_carrier_det(w_carrier_det)
    );

    assign w_rise       = w_carrier_det & ~r_cd_d;
    assign w_trans      = w_carrier_det ^ r_cd_d;
    assign w_ones_sum   = {1'b0, r_ones_cnt} + {{BW{1'b0}}, w_carrier_det};
    assign w_twice_ones = {r_ones_cnt, 1'b0};
    assign w_cnt_plus1  = {1'b0, r_bit_cnt} + (BW + 1)'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_ones_cnt   <= '0;
            r_zero_run   <= '0;
            r_cd_d       <= 1'b0;
            r_data_out   <= 1'b0;
            r_data_valid <= 1'b0;
            r_bit_clk    <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_ones_cnt   <= w_ones_cnt_nx;
            r_zero_run   <= w_zero_run_nx;
            r_cd_d       <= w_carrier_det;
            r_data_out   <= w_data_out_nx;
            r_data_valid <= w_data_valid_nx;
            r_bit_clk    <= w_bit_clk_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_bit_cnt_nx    = r_bit_cnt;
        w_ones_cnt_nx   = r_ones_cnt;
        w_zero_run_nx   = r_zero_run;
        w_data_out_nx   = r_data_out;
        w_data_valid_nx = 1'b0;
        w_decide        = 1'b0;
        w_dec_bit       = 1'b0;
        case (r_state)
            IDLE: begin
                w_bit_cnt_nx  = '0;
                w_ones_cnt_nx = '0;
                w_zero_run_nx = '0;
                if (w_rise) begin
                    w_state_nx = TRACK;
                end
            end
            TRACK: begin
                // A full zero run drops lock one cycle after its final decision,
                // unless the carrier reappears in that very cycle.
                if (r_zero_run == ZMAX) begin
                    w_bit_cnt_nx  = '0;
                    w_ones_cnt_nx = '0;
                    w_zero_run_nx = '0;
                    if (!w_rise) begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    if (r_bit_cnt == LAST) begin
                        w_decide  = 1'b1;
                        w_dec_bit = (w_ones_sum >= HALF_W);
                    end else if (w_trans && (r_bit_cnt >= HALF)) begin
                        w_decide  = 1'b1;
                        w_dec_bit = (w_twice_ones >= w_cnt_plus1);
                    end
                    if (w_decide) begin
                        w_data_valid_nx = 1'b1;
                        w_data_out_nx   = w_dec_bit;
                        w_bit_cnt_nx    = '0;
                        w_ones_cnt_nx   = '0;
                        w_zero_run_nx   = w_dec_bit ? '0 : r_zero_run + ZW'(1);
                    end else begin
                        w_bit_cnt_nx  = r_bit_cnt + BW'(1);
                        w_ones_cnt_nx = w_ones_sum[BW-1:0];
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
        w_bit_clk_nx = (w_state_nx == TRACK) && (w_bit_cnt_nx < HALF);
    end

    assign carrier_det = w_carrier_det;
    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign bit_clk     = r_bit_clk;
    assign locked      = (r_state == TRACK);

endmodule

// File: tb/tb_ook_demod.sv
// Randomized scoreboard bench for ook_demod with a shortened bit period.
module tb_ook_demod;

    localparam int unsigned BITC  = 200;
    localparam int unsigned GAP   = 50;
    localparam int unsigned CDIV  = 25;
    localparam int unsigned IDLEB = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic mod_in = 1'b0;
    logic carrier_det, data_out, data_valid, bit_clk, locked;

    always #5 clk = ~clk;

    ook_demod #(
        .CARRIER_DIV(CDIV),
        .BIT_CYCLES (BITC),
        .GAP_CYCLES (GAP),
        .IDLE_BITS  (IDLEB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mod_in     (mod_in),
        .carrier_det(carrier_det),
        .data_out   (data_out),
        .data_valid (data_valid),
        .bit_clk    (bit_clk),
        .locked     (locked)
    );

    typedef struct {
        bit d;
        int stamp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    // Reference model state (values visible after the latest clock edge).
    int ecount = 0;
    bit sprev  = 1'b0;
    int rises[$];
    bit m_cd = 0, m_cdp = 0, m_lock = 0, m_data = 0, m_bclk = 0;
    int m_bc = 0, m_ones = 0, m_zr = 0;
    bit c_cur, c_prev, ncd, decide, dbit;
    exp_t e_new;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprev = 1'b0;
            rises.delete();
            m_cd = 0; m_cdp = 0; m_lock = 0; m_data = 0; m_bclk = 0;
            m_bc = 0; m_ones = 0; m_zr = 0;
        end else begin
            c_cur  = m_cd;
            c_prev = m_cdp;
            // Carrier is present while some input rising edge lies 4..GAP+3 samples back.
            ecount++;
            if (mod_in && !sprev) rises.push_back(ecount);
            sprev = mod_in;
            while (rises.size() > 0 && (ecount - rises[0]) > int'(GAP) + 3) void'(rises.pop_front());
            ncd = 1'b0;
            foreach (rises[i]) if (ecount - rises[i] >= 4) ncd = 1'b1;

            if (!m_lock) begin
                m_bc = 0; m_ones = 0; m_zr = 0;
                if (c_cur && !c_prev) m_lock = 1;
            end else if (m_zr == int'(IDLEB)) begin
                m_bc = 0; m_ones = 0; m_zr = 0;
                if (!(c_cur && !c_prev)) m_lock = 0;
            end else begin
                decide = 0;
                dbit   = 0;
                if (m_bc == int'(BITC) - 1) begin
                    decide = 1;
                    dbit   = (m_ones + int'(c_cur)) >= int'(BITC / 2);
                end else if ((c_cur != c_prev) && m_bc >= int'(BITC / 2)) begin
                    decide = 1;
                    dbit   = (2 * m_ones) >= (m_bc + 1);
                end
                if (decide) begin
                    e_new.d = dbit;
                    e_new.stamp = ncyc;
                    exp_q.push_back(e_new);
                    m_data = dbit;
                    m_bc = 0; m_ones = 0;
                    m_zr = dbit ? 0 : m_zr + 1;
                end else begin
                    m_bc++;
                    m_ones += int'(c_cur);
                end
            end
            m_cdp  = c_cur;
            m_cd   = ncd;
            m_bclk = m_lock && (m_bc < int'(BITC / 2));
        end
    end

    task automatic chk(input string name, input logic act, input bit exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, ncyc);
        end
    endtask

    bit   exp_dv;
    exp_t e_pop;

    always @(negedge clk) begin
        chk("carrier_det", carrier_det, m_cd);
        chk("locked", locked, m_lock);
        chk("bit_clk", bit_clk, m_bclk);
        chk("data_out", data_out, m_data);
        exp_dv = (exp_q.size() > 0) && (exp_q[0].stamp == ncyc);
        chk("data_valid", data_valid, exp_dv);
        if (exp_dv) begin
            e_pop = exp_q.pop_front();
            chk("decided_bit", data_out, e_pop.d);
        end
        ncyc++;
    end

    int ph = 0;

    task automatic drive_cycles(input bit on, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            mod_in = on && (ph < int'(CDIV / 2));
            ph = (ph + 1) % int'(CDIV);
        end
    endtask

    initial begin
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        drive_cycles(1'b0, 2000);
        ph = 0;
        foreach (pat[i]) drive_cycles(pat[i], BITC);
        drive_cycles(1'b0, 12 * BITC);
        for (int i = 0; i < 70; i++) begin
            drive_cycles(1'($urandom_range(0, 1)), int'(BITC) - 100 + int'($urandom_range(0, 140)));
        end
        drive_cycles(1'b0, 12 * BITC);
        // Carrier drops part-way through a bit, forcing an early boundary.
        drive_cycles(1'b1, 3 * BITC + 140);
        drive_cycles(1'b0, 3 * BITC);
        drive_cycles(1'b1, BITC + 100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        drive_cycles(1'b1, 3);
        rst_n = 1'b1;
        drive_cycles(1'b1, 2 * BITC);
        drive_cycles(1'b0, 12 * BITC);
        drive_cycles(1'b0, 100);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_decisions: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ook_demod.md
Name: ook_demod

Overview:
- Receive-side counterpart of the transmit clock/carrier chain: takes the 1-bit on-off-keyed signal (2 MHz carrier gated by data at the message clock rate) and recovers the data bits and the bit clock.
- Runs on the 50 MHz system clock.
- Detects carrier presence, locks bit timing to carrier on/off transitions, and makes a majority decision per bit period.
- Emits one data_valid pulse per recovered bit.

Parameters:
- CARRIER_DIV, 25: nominal carrier period in clk cycles. Informational only; GAP_CYCLES must be at least 2*CARRIER_DIV.
- BIT_CYCLES, 12500: bit period in clk cycles (one full message-clock period). Must be even and at least 8.
- GAP_CYCLES, 50: clk cycles without a carrier rising edge before the carrier is declared absent.
- IDLE_BITS, 8: consecutive decided 0 bits that drop lock.

Ports:
- clk, input, 1: system clock, 50 MHz; all logic is on its rising edge.
- rst_n, input, 1: reset.
- mod_in, input, 1: OOK modulated input; may be asynchronous to clk.
- carrier_det, output, 1: carrier currently present.
- data_out, output, 1: last decided bit; holds between decisions.
- data_valid, output, 1: one-cycle pulse when data_out is updated.
- bit_clk, output, 1: recovered bit clock; high during the first half of each bit in TRACK.
- locked, output, 1: block is in TRACK state.

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n low, async): sync flops = 0, gap_cnt = GAP_CYCLES (saturated), state = IDLE. All outputs = 0: carrier_det, data_out, data_valid, bit_clk, locked.
- Input sync: 2-flop synchronizer on mod_in, then a third flop for rising-edge detect. edge_p is a registered 1-cycle pulse.
- Gap counter, width clog2(GAP_CYCLES+1): edge_p clears it to 0; otherwise it increments, saturating at GAP_CYCLES.
- carrier_det = (gap_cnt < GAP_CYCLES), registered.
- carrier_det assert latency: first mod_in high sampled at edge k gives carrier_det = 1 after edge k+4.
- carrier_det deassert: exactly GAP_CYCLES+1 cycles after the last edge_p.
- States:
  - IDLE: bit_cnt = 0, ones_cnt = 0, zero_run = 0, no data_valid. A carrier_det 0->1 transition moves to TRACK with bit_cnt = 0.
  - TRACK: bit_cnt counts 0..BIT_CYCLES-1 and wraps. ones_cnt adds carrier_det every cycle.
- Normal decision: at bit_cnt == BIT_CYCLES-1, data_out = 1 iff (ones_cnt + carrier_det) >= BIT_CYCLES/2. Pulse data_valid, then reset bit_cnt and ones_cnt to 0.
- Resync, any carrier_det transition in TRACK:
  - bit_cnt < BIT_CYCLES/2: no action (treated as aligned boundary / detector lag).
  - bit_cnt >= BIT_CYCLES/2: early boundary. Decide immediately with data_out = 1 iff 2*ones_cnt >= bit_cnt+1, pulse data_valid, restart bit_cnt = 0 and ones_cnt = 0 next cycle.
  - A transition coinciding with bit_cnt == BIT_CYCLES-1 produces a single decision, never two.
- zero_run: each decided 0 increments it; a decided 1 clears it. When a decision makes zero_run reach IDLE_BITS, that decision still pulses data_valid, then state goes to IDLE the next cycle. locked and bit_clk are low from that cycle on.
- If a carrier_det 0->1 occurs in the same cycle as lock loss, return directly to TRACK with bit_cnt = 0.
- bit_clk = locked && (bit_cnt < BIT_CYCLES/2), registered.
- locked = (state == TRACK).
- Widths: bit_cnt and ones_cnt are clog2(BIT_CYCLES) bits; zero_run is clog2(IDLE_BITS+1) bits. No overflow is possible given the wrap rules.
- Reset mid-operation: immediate return to reset values; the partial bit is discarded with no data_valid.

Decomposition:
- Package ook_pkg: state enum {IDLE, TRACK}; default constants CARRIER_DIV, BIT_CYCLES, GAP_CYCLES, IDLE_BITS.
- One sub-module, carrier_detect: synchronizer, edge detect, gap counter; outputs carrier_det.
- Top holds the FSM, bit timing, majority decision and zero-run logic.

Test Plan:
- Reset, then mod_in = 0 for 100000 cycles -> all outputs 0, no data_valid.
- 2 MHz carrier (25-cycle period) starting at cycle 1000 -> carrier_det high at 1004+(0..1); locked high one cycle later; bit_clk toggles every 6250 cycles.
- Data pattern 1,0,1,1,0 at 12500 cycles/bit -> data_valid exactly once per bit; data_out sequence 1,0,1,1,0.
- Carrier stops (mod_in = 0) after 3 ones -> carrier_det low 51 cycles after the last edge; then 8 zero decisions; locked drops the cycle after the 8th data_valid.
- Bit boundary shifted so the carrier turns off at bit_cnt = 9000 -> early decision data_out = 1 at that point; the next bit restarts at bit_cnt = 0; no double pulse.
- rst_n pulsed low at bit_cnt = 5000 in TRACK -> outputs 0 immediately, no data_valid; re-lock on the next carrier edge.
